// File: rtl/lamp_fpu_tay_round_pack_pkg.sv
// Shared exponential-datapath types: rounding modes, exception flags and bfloat16 special encodings.
// Optional LAMP_TAY_ROUND_MODES_EN selects the non-RNE modes in the users of this package.
package lamp_fpu_tay_round_pack_pkg;

    localparam int E_DW  = 8;
    localparam int F_DW  = 7;
    localparam int RES_W = 1 + E_DW + F_DW;

    typedef enum logic [2:0] {
        RND_RNE = 3'd0,
        RND_RTZ = 3'd1,
        RND_RDN = 3'd2,
        RND_RUP = 3'd3,
        RND_RMM = 3'd4
    } rnd_mode_t;

    typedef struct packed {
        logic of;
        logic uf;
        logic nx;
        logic err;
    } flags_t;

    localparam logic [E_DW-1:0] INF_E    = '1;
    localparam logic [E_DW-1:0] MAXFIN_E = {{(E_DW-1){1'b1}}, 1'b0};
    localparam logic [F_DW-1:0] MAXFIN_F = '1;

    typedef struct packed {
        logic [RES_W-1:0] res;
        flags_t           flags;
    } entry_t;

endpackage

// File: rtl/lamp_fpu_tay_round_pack_if.sv
// Bus between the Taylor add/sub stage, the round/pack stage and its consumer.
// rnd_mode_i exists only when LAMP_TAY_ROUND_MODES_EN is defined.
interface lamp_fpu_tay_round_pack_if;
    import lamp_fpu_tay_round_pack_pkg::*;

    logic               in_valid_i;
    logic               in_ready_o;
    logic               s_i;
    logic [E_DW-1:0]    e_i;
    logic [F_DW+4:0]    f_i;
    logic               isToRound_i;
    logic               isOverflow_i;
    logic               isUnderflow_i;
`ifdef LAMP_TAY_ROUND_MODES_EN
    logic [2:0]         rnd_mode_i;
`endif
    logic               out_valid_o;
    logic               out_ready_i;
    logic [RES_W-1:0]   res_o;
    flags_t             flags_o;
    flags_t             flags_acc_o;
    logic               clr_flags_i;

    modport master (
        output in_valid_i, s_i, e_i, f_i, isToRound_i, isOverflow_i, isUnderflow_i,
`ifdef LAMP_TAY_ROUND_MODES_EN
        output rnd_mode_i,
`endif
        output out_ready_i, clr_flags_i,
        input  in_ready_o, out_valid_o, res_o, flags_o, flags_acc_o
    );

    modport slave (
        input  in_valid_i, s_i, e_i, f_i, isToRound_i, isOverflow_i, isUnderflow_i,
`ifdef LAMP_TAY_ROUND_MODES_EN
        input  rnd_mode_i,
`endif
        input  out_ready_i, clr_flags_i,
        output in_ready_o, out_valid_o, res_o, flags_o, flags_acc_o
    );

endinterface

// File: rtl/lamp_fpu_tay_round_pack_rnd_core.sv
// Combinational round + pack of one add/sub result into a bfloat16 word with per-op flags.
// LAMP_TAY_ROUND_MODES_EN adds the mode_i port and the RTZ/RDN/RUP/RMM modes.
module lamp_fpu_tay_rnd_core
    import lamp_fpu_tay_round_pack_pkg::*;
(
    input  logic             s_i,
    input  logic [E_DW-1:0]  e_i,
    input  logic [F_DW+4:0]  f_i,
    input  logic             isToRound_i,
    input  logic             isOverflow_i,
    input  logic             isUnderflow_i,
`ifdef LAMP_TAY_ROUND_MODES_EN
    input  rnd_mode_t        mode_i,
`endif
    output logic [RES_W-1:0] res_o,
    output flags_t           flags_o
);

    logic            guard, sticky, lsb, inexact, roundUp, saturate;
    logic [F_DW+1:0] mant;
    logic [E_DW:0]   expSum;
    logic [E_DW-1:0] expOut;
    logic [F_DW-1:0] fracOut;
    flags_t          flags;
    logic            unusedOvfBit;

    // Upstream overflow is signalled through isOverflow_i, so f's own ovf bit is not needed here.
    assign unusedOvfBit = f_i[F_DW+4];

    always_comb begin
        guard    = f_i[2];
        sticky   = f_i[1] | f_i[0];
        lsb      = f_i[3];
        inexact  = guard | sticky;
        roundUp  = guard & (sticky | lsb);
        saturate = 1'b0;
`ifdef LAMP_TAY_ROUND_MODES_EN
        // Directed modes that round toward zero on overflow saturate to max finite instead of Inf.
        case (mode_i)
            RND_RTZ: begin
                roundUp  = 1'b0;
                saturate = 1'b1;
            end
            RND_RDN: begin
                roundUp  = s_i & inexact;
                saturate = ~s_i;
            end
            RND_RUP: begin
                roundUp  = ~s_i & inexact;
                saturate = s_i;
            end
            RND_RMM: roundUp = guard;
            default: ;
        endcase
`endif
        mant   = {1'b0, f_i[F_DW+3:3]} + {{(F_DW+1){1'b0}}, roundUp};
        expSum = {1'b0, e_i} + {{E_DW{1'b0}}, mant[F_DW+1]};
        if (e_i == '0 && mant[F_DW]) begin
            expSum = {{E_DW{1'b0}}, 1'b1};
        end
        expOut  = expSum[E_DW-1:0];
        fracOut = mant[F_DW-1:0];
        flags   = '0;
        if (isOverflow_i || expSum >= {1'b0, INF_E}) begin
            flags.of = 1'b1;
            expOut   = saturate ? MAXFIN_E : INF_E;
            fracOut  = saturate ? MAXFIN_F : '0;
        end
        flags.nx = inexact | isOverflow_i;
        flags.uf = isUnderflow_i | ((expOut == '0) & flags.nx);
        res_o    = {s_i, expOut, fracOut};
        flags_o  = flags;
        if (!isToRound_i) begin
            res_o   = {s_i, e_i, f_i[F_DW+2:3]};
            flags_o = '0;
        end
    end

endmodule

// File: rtl/lamp_fpu_tay_round_pack.sv
// Round/pack stage: rounds at accept, then buffers results in a main+skid pair with a sticky flag accumulator.
// LAMP_TAY_ROUND_MODES_EN enables the rnd_mode_i selectable rounding modes.
module lamp_fpu_tay_round_pack
    import lamp_fpu_tay_round_pack_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    lamp_fpu_tay_round_pack_if.slave bus
);

    localparam flags_t ERR_FLAG = '{of: 1'b0, uf: 1'b0, nx: 1'b0, err: 1'b1};

    entry_t newEntry;
    entry_t main_q, main_d, skid_q, skid_d;
    logic   mainValid_q, mainValid_d, skidValid_q, skidValid_d;
    flags_t acc_q, acc_d;
    logic   accept, fire, drop;

    lamp_fpu_tay_rnd_core u_core (
        .s_i           (bus.s_i),
        .e_i           (bus.e_i),
        .f_i           (bus.f_i),
        .isToRound_i   (bus.isToRound_i),
        .isOverflow_i  (bus.isOverflow_i),
        .isUnderflow_i (bus.isUnderflow_i),
`ifdef LAMP_TAY_ROUND_MODES_EN
        .mode_i        (rnd_mode_t'(bus.rnd_mode_i)),
`endif
        .res_o         (newEntry.res),
        .flags_o       (newEntry.flags)
    );

    assign accept          = bus.in_valid_i & ~skidValid_q;
    assign drop            = bus.in_valid_i & skidValid_q;
    assign fire            = mainValid_q & bus.out_ready_i;
    assign bus.in_ready_o  = ~skidValid_q;
    assign bus.out_valid_o = mainValid_q;
    assign bus.res_o       = main_q.res;
    assign bus.flags_o     = main_q.flags;
    assign bus.flags_acc_o = acc_q;

    // Skid refills main first so results leave in arrival order; a new op only lands in skid while main is stuck.
    always_comb begin
        main_d      = main_q;
        skid_d      = skid_q;
        mainValid_d = mainValid_q;
        skidValid_d = skidValid_q;
        if (skidValid_q) begin
            if (fire) begin
                main_d      = skid_q;
                skidValid_d = 1'b0;
            end
        end else if (accept) begin
            if (!mainValid_q || fire) begin
                main_d      = newEntry;
                mainValid_d = 1'b1;
            end else begin
                skid_d      = newEntry;
                skidValid_d = 1'b1;
            end
        end else if (fire) begin
            mainValid_d = 1'b0;
        end
        acc_d = (bus.clr_flags_i ? flags_t'('0) : acc_q)
              | (fire ? main_q.flags : flags_t'('0))
              | (drop ? ERR_FLAG : flags_t'('0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q      <= '0;
            skid_q      <= '0;
            mainValid_q <= 1'b0;
            skidValid_q <= 1'b0;
            acc_q       <= '0;
        end else begin
            main_q      <= main_d;
            skid_q      <= skid_d;
            mainValid_q <= mainValid_d;
            skidValid_q <= skidValid_d;
            acc_q       <= acc_d;
        end
    end

endmodule
